// File: rtl/frame_rd_pkg.sv
// Shared types and helpers for the frame buffer read stage.
//   state_t     : read stage FSM encoding (IDLE / STREAM / DRAIN)
//   ASSERT_*    : polarity constants for active-low / active-high strobes
//   clog2       : elaboration-time ceil(log2(value))
package frame_rd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  localparam logic ASSERT_L   = 1'b0;
  localparam logic DEASSERT_L = 1'b1;
  localparam logic ASSERT_H   = 1'b1;
  localparam logic DEASSERT_H = 1'b0;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/pix_fifo.sv
// Synchronous first-word-fall-through FIFO for returned pixel data.
//   clk, reset : clock, synchronous active-low reset (empties the FIFO)
//   push, din  : write request and data; accepted when not full, or when
//                full and a pop happens in the same cycle
//   pop        : read request; ignored while empty
//   dout       : head entry, valid whenever empty is low
//   empty/full : status flags; count is the exact number of entries
module pix_fifo
  import frame_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push,
  input  logic                           pop,
  input  logic [DATA_WIDTH-1:0]          din,
  output logic [DATA_WIDTH-1:0]          dout,
  output logic                           empty,
  output logic                           full,
  output logic [clog2(FIFO_DEPTH):0]     count
);

  localparam int AW = clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         cnt;
  logic                  do_push, do_pop;

  assign do_pop  = pop & (cnt != '0);
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign do_push = push & ((cnt != DEPTH_C) | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign empty = (cnt == '0);
  assign full  = (cnt == DEPTH_C);
  assign count = cnt;

endmodule

// File: rtl/frame_rd_stage.sv
// Frame buffer read-side consumer.
// Issues reads toward the frame buffer with an active-low, registered rd_en_n
// under credit control (FIFO entries plus reads still in flight), captures the
// returned Avalon beats in a FWFT FIFO and presents them as a valid/ready pixel
// stream tagged with start/end of frame.
//   clk, reset        : clock, synchronous active-low reset
//   start             : level; keep streaming frames while high
//   rd_en_n           : read request to the frame buffer (active low)
//   avl_read_req/ready: observed to count issued reads
//   avl_rdata_valid/avl_rdata : returned read data
//   rd_done           : frame buffer end-of-frame pulse, cross-checked
//   pix_valid/ready/data/sof/eof : pixel stream
//   frame_done        : pulse the cycle after the last pixel handshake
//   ovf, sync_err     : sticky error flags, cleared only by reset
module frame_rd_stage
  import frame_rd_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int FIFO_DEPTH   = 16,
  parameter int FRAME_PIXELS = 307200,
  parameter int SLACK        = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  rd_en_n,
  input  logic                  avl_read_req,
  input  logic                  avl_ready,
  input  logic                  avl_rdata_valid,
  input  logic [DATA_WIDTH-1:0] avl_rdata,
  input  logic                  rd_done,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic [DATA_WIDTH-1:0] pix_data,
  output logic                  pix_sof,
  output logic                  pix_eof,
  output logic                  frame_done,
  output logic                  ovf,
  output logic                  sync_err
);

  localparam int CW = clog2(FIFO_DEPTH) + 1;
  // Wide enough that fifo count + outstanding + SLACK cannot wrap.
  localparam int OW = CW + 2;
  // Frame counters must be able to hold FRAME_PIXELS itself.
  localparam int PW = clog2(FRAME_PIXELS + 1);

  localparam logic [PW-1:0] FP_L    = PW'(FRAME_PIXELS);
  localparam logic [PW-1:0] FP_LAST = PW'(FRAME_PIXELS - 1);
  localparam logic [OW-1:0] SLACK_W = OW'(SLACK);
  localparam logic [OW-1:0] DEPTH_W = OW'(FIFO_DEPTH);

  state_t        state, state_nx;
  logic [PW-1:0] req_cnt, req_nx, pix_cnt, pix_nx;
  logic [CW-1:0] outst, outst_nx, fifo_count, fifo_cnt_nx;
  logic [OW-1:0] occ_w;
  logic          fifo_empty, fifo_full;
  logic          issue, ret, pop, push_ok, ret_dec;
  logic          ovf_set, sync_set, rd_en_n_nx, frame_done_nx;

  pix_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_ok),
    .pop   (pop),
    .din   (avl_rdata),
    .dout  (pix_data),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  assign pix_valid = ~fifo_empty;
  assign pix_sof   = pix_valid & (pix_cnt == '0);
  assign pix_eof   = pix_valid & (pix_cnt == FP_LAST);

  always_comb begin
    issue    = avl_read_req & avl_ready & (state != IDLE);
    ret      = avl_rdata_valid & (state != IDLE);
    pop      = pix_valid & pix_ready;
    push_ok  = ret & (~fifo_full | pop);
    ovf_set  = ret & fifo_full & ~pop;
    // A beat with nothing in flight is an error; outstanding never goes negative.
    ret_dec  = ret & (outst != '0);
    sync_set = (ret & (outst == '0)) |
               (rd_done & (req_cnt != FP_L) & (state != DRAIN));

    outst_nx    = outst + CW'(issue) - CW'(ret_dec);
    fifo_cnt_nx = fifo_count + CW'(push_ok) - CW'(pop);

    req_nx = req_cnt;
    if (issue && (state == STREAM) && (req_cnt < FP_L)) req_nx = req_cnt + PW'(1);
    pix_nx = pix_cnt;
    if (pop && (pix_cnt < FP_L)) pix_nx = pix_cnt + PW'(1);

    state_nx      = state;
    frame_done_nx = DEASSERT_H;
    case (state)
      IDLE:   if (start) state_nx = STREAM;
      STREAM: if (req_nx == FP_L) state_nx = DRAIN;
      DRAIN: begin
        if (pix_nx == FP_L) begin
          frame_done_nx = ASSERT_H;
          req_nx        = '0;
          pix_nx        = '0;
          state_nx      = start ? STREAM : IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase

    // Credit check uses the post-edge occupancy (this cycle's issue, return
    // and pop included) so the registered rd_en_n never over-requests; SLACK
    // covers the frame buffer's own request latency.
    occ_w      = OW'(fifo_cnt_nx) + OW'(outst_nx) + SLACK_W;
    rd_en_n_nx = ((state_nx == STREAM) && (occ_w < DEPTH_W) && (req_nx < FP_L))
                 ? ASSERT_L : DEASSERT_L;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      req_cnt    <= '0;
      pix_cnt    <= '0;
      outst      <= '0;
      rd_en_n    <= DEASSERT_L;
      frame_done <= DEASSERT_H;
      ovf        <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      state      <= state_nx;
      req_cnt    <= req_nx;
      pix_cnt    <= pix_nx;
      outst      <= outst_nx;
      rd_en_n    <= rd_en_n_nx;
      frame_done <= frame_done_nx;
      ovf        <= ovf | ovf_set;
      sync_err   <= sync_err | sync_set;
    end
  end

endmodule

// File: tb/tb_frame_rd_stage.sv
module tb_frame_rd_stage;

  localparam int DW = 32;
  localparam int FD = 16;
  localparam int FP = 32;

  logic          clk, reset, start, rd_en_n, avl_read_req, avl_ready;
  logic          avl_rdata_valid, rd_done, pix_valid, pix_ready;
  logic          pix_sof, pix_eof, frame_done, ovf, sync_err;
  logic [DW-1:0] avl_rdata, pix_data;

  logic          mem_en, inj_v;
  logic [DW-1:0] inj_d;
  logic [2:0]    mv;
  logic [DW-1:0] md [3];
  logic [DW-1:0] mcnt;

  int n_cmp = 0;
  int n_err = 0;
  int iss, npix, nfd;
  logic [DW-1:0] pd [128];
  logic          ps [128];
  logic          pe [128];

  frame_rd_stage #(
    .DATA_WIDTH (DW), .FIFO_DEPTH (FD), .FRAME_PIXELS (FP), .SLACK (2)
  ) dut (
    .clk (clk), .reset (reset), .start (start), .rd_en_n (rd_en_n),
    .avl_read_req (avl_read_req), .avl_ready (avl_ready),
    .avl_rdata_valid (avl_rdata_valid), .avl_rdata (avl_rdata),
    .rd_done (rd_done), .pix_valid (pix_valid), .pix_ready (pix_ready),
    .pix_data (pix_data), .pix_sof (pix_sof), .pix_eof (pix_eof),
    .frame_done (frame_done), .ovf (ovf), .sync_err (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: a read issued in cycle c returns its index in cycle c+3.
  assign avl_read_req    = mem_en & ~rd_en_n;
  assign avl_rdata_valid = mv[2] | inj_v;
  assign avl_rdata       = inj_v ? inj_d : md[2];

  always @(posedge clk) begin
    if (!reset) begin
      mv   <= '0;
      mcnt <= '0;
    end else begin
      mv    <= {mv[1:0], avl_read_req & avl_ready};
      md[0] <= mcnt;
      md[1] <= md[0];
      md[2] <= md[1];
      if (avl_read_req && avl_ready) mcnt <= mcnt + 1;
    end
  end

  // Monitor: issued reads, handshaked pixels and frame_done pulses.
  always @(negedge clk) begin
    if (!reset) begin
      iss = 0; npix = 0; nfd = 0;
    end else begin
      if (avl_read_req && avl_ready) iss++;
      if (pix_valid && pix_ready && npix < 128) begin
        pd[npix] = pix_data; ps[npix] = pix_sof; pe[npix] = pix_eof;
        npix++;
      end
      if (frame_done) nfd++;
    end
  end

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 0; start = 0; pix_ready = 0; mem_en = 0; inj_v = 0; rd_done = 0;
    inj_d = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1;
  endtask

  task automatic wait_fd(input string name, input int budget);
    int t;
    t = 0;
    while (frame_done !== 1'b1 && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk1(name, frame_done, 1'b1);
  endtask

  task automatic check_frame(input int first, input logic [31:0] base);
    for (int i = 0; i < FP; i++) begin
      chk32($sformatf("pix_data[%0d]", first + i), pd[first + i], base + 32'(i));
      chk1($sformatf("pix_sof[%0d]", first + i), ps[first + i], i == 0);
      chk1($sformatf("pix_eof[%0d]", first + i), pe[first + i], i == FP - 1);
    end
  endtask

  typedef struct {
    logic          inj_v;
    logic [DW-1:0] inj_d;
    logic          rdy;
    logic          exp_v;
    logic [DW-1:0] exp_d;
    logic          exp_sof;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int t, loc;
    // inj_v, inj_d, pix_ready | pix_valid, pix_data, pix_sof (same cycle)
    tbl[0] = '{1'b1, 32'hA0, 1'b0, 1'b0, 32'h0,  1'b0};
    tbl[1] = '{1'b1, 32'hA1, 1'b0, 1'b1, 32'hA0, 1'b1};
    tbl[2] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'hA0, 1'b1};
    tbl[3] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'hA1, 1'b0};
    tbl[4] = '{1'b1, 32'hA2, 1'b1, 1'b0, 32'h0,  1'b0};
    tbl[5] = '{1'b0, 32'h0,  1'b0, 1'b1, 32'hA2, 1'b0};
    tbl[6] = '{1'b1, 32'hA3, 1'b1, 1'b1, 32'hA2, 1'b0};
    tbl[7] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'hA3, 1'b0};
    tbl[8] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  1'b0};

    reset = 0; start = 0; pix_ready = 0; mem_en = 0; inj_v = 0; inj_d = '0;
    rd_done = 0; avl_ready = 1;

    // Reset state
    do_reset();
    @(negedge clk);
    chk1("rst_rd_en_n", rd_en_n, 1'b1);
    chk1("rst_pix_valid", pix_valid, 1'b0);
    chk1("rst_sof", pix_sof, 1'b0);
    chk1("rst_eof", pix_eof, 1'b0);
    chk1("rst_frame_done", frame_done, 1'b0);
    chk1("rst_ovf", ovf, 1'b0);
    chk1("rst_sync_err", sync_err, 1'b0);

    // FWFT timing and sof tagging with injected beats, no reads outstanding
    do_reset();
    start = 1;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      inj_v = tbl[i].inj_v; inj_d = tbl[i].inj_d; pix_ready = tbl[i].rdy;
      @(negedge clk);
      chk1($sformatf("vec%0d_valid", i), pix_valid, tbl[i].exp_v);
      chk1($sformatf("vec%0d_sof", i), pix_sof, tbl[i].exp_sof);
      if (tbl[i].exp_v) chk32($sformatf("vec%0d_data", i), pix_data, tbl[i].exp_d);
    end
    @(posedge clk); #1 inj_v = 0;
    chk1("vec_sync_err_unsolicited", sync_err, 1'b1);
    chk1("vec_ovf", ovf, 1'b0);

    // Plan 1: one 32-pixel frame, 3-cycle memory latency
    do_reset();
    start = 1; mem_en = 1; pix_ready = 1;
    repeat (2) @(posedge clk);
    #1 start = 0;
    wait_fd("t1_frame_done", 400);
    repeat (10) @(negedge clk);
    chk32("t1_issued", iss, FP);
    chk32("t1_pixels", npix, FP);
    chk32("t1_frame_done_cnt", nfd, 1);
    chk1("t1_rd_en_n_idle", rd_en_n, 1'b1);
    chk1("t1_ovf", ovf, 1'b0);
    chk1("t1_sync_err", sync_err, 1'b0);
    check_frame(0, 32'd0);

    // Plan 2: back-pressure stops credits at FD - SLACK
    do_reset();
    start = 1; mem_en = 1; pix_ready = 0;
    repeat (40) @(posedge clk);
    #1;
    chk32("t2_issued_stall", iss, 14);
    chk1("t2_rd_en_n_held", rd_en_n, 1'b1);
    chk1("t2_pix_valid", pix_valid, 1'b1);
    chk1("t2_sof_head", pix_sof, 1'b1);
    chk32("t2_head_data", pix_data, 32'd0);
    chk1("t2_ovf", ovf, 1'b0);
    pix_ready = 1; start = 0;
    wait_fd("t2_frame_done", 400);
    repeat (5) @(negedge clk);
    chk32("t2_issued_total", iss, FP);
    chk32("t2_pixels", npix, FP);
    chk32("t2_last_pixel", pd[FP-1], 32'(FP - 1));

    // Plan 3: push into a full FIFO without and with a pop
    do_reset();
    start = 1; mem_en = 0; pix_ready = 0;
    @(posedge clk); #1;
    for (int i = 0; i < FD; i++) begin
      inj_v = 1; inj_d = 32'(100 + i);
      @(posedge clk); #1;
    end
    chk1("t3_ovf_before", ovf, 1'b0);
    inj_d = 32'd200;
    @(posedge clk); #1 inj_v = 0;
    chk1("t3_ovf_set", ovf, 1'b1);
    chk32("t3_head_kept", pix_data, 32'd100);
    repeat (5) @(posedge clk);
    #1 chk1("t3_ovf_sticky", ovf, 1'b1);
    do_reset();
    chk1("t3_ovf_cleared", ovf, 1'b0);
    start = 1;
    @(posedge clk); #1;
    for (int i = 0; i < FD; i++) begin
      inj_v = 1; inj_d = 32'(100 + i);
      @(posedge clk); #1;
    end
    inj_d = 32'd200; pix_ready = 1;
    @(posedge clk); #1 inj_v = 0; pix_ready = 0;
    chk1("t3_ovf_popsame", ovf, 1'b0);
    chk32("t3_head_after_pop", pix_data, 32'd101);
    pix_ready = 1;
    repeat (20) @(posedge clk);
    #1;
    chk32("t3_drained", npix, FD + 1);
    chk32("t3_last_kept", pd[FD], 32'd200);

    // Plan 4: back-to-back frames with start held
    do_reset();
    start = 1; mem_en = 1; pix_ready = 1;
    wait_fd("t4_fd1", 400);
    chk1("t4_restart_rd_en", rd_en_n, 1'b0);
    @(posedge clk); #1 start = 0;
    @(negedge clk);
    wait_fd("t4_fd2", 400);
    repeat (5) @(negedge clk);
    chk32("t4_frames", nfd, 2);
    chk32("t4_issued", iss, 2 * FP);
    chk32("t4_pixels", npix, 2 * FP);
    chk1("t4_eof_f1", pe[FP-1], 1'b1);
    chk1("t4_sof_f2", ps[FP], 1'b1);
    chk32("t4_data_f2", pd[FP], 32'(FP));
    chk1("t4_eof_f2", pe[2*FP-1], 1'b1);

    // Plan 5: reset mid-frame, then a late beat in IDLE
    do_reset();
    start = 1; mem_en = 1; pix_ready = 1;
    t = 0;
    while (npix < 3 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk1("t5_reached_px3", npix >= 3, 1'b1);
    @(posedge clk); #1 reset = 0; start = 0;
    @(posedge clk); #1;
    chk1("t5_rd_en_n", rd_en_n, 1'b1);
    chk1("t5_pix_valid", pix_valid, 1'b0);
    chk1("t5_sof", pix_sof, 1'b0);
    chk1("t5_eof", pix_eof, 1'b0);
    chk1("t5_frame_done", frame_done, 1'b0);
    chk1("t5_ovf", ovf, 1'b0);
    chk1("t5_sync_err", sync_err, 1'b0);
    reset = 1;
    @(posedge clk); #1 inj_v = 1; inj_d = 32'hDEAD;
    @(posedge clk); #1 inj_v = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk1($sformatf("t5_idle_valid%0d", i), pix_valid, 1'b0);
    end
    chk1("t5_idle_sync_err", sync_err, 1'b0);

    // Plan 6: early rd_done flags sync_err, frame still completes
    do_reset();
    start = 1; mem_en = 1; pix_ready = 1;
    loc = 0; t = 0;
    while (loc < 4 && t < 100) begin
      @(negedge clk);
      if (avl_read_req && avl_ready) loc++;
      t++;
    end
    chk32("t6_reached_4", loc, 4);
    @(posedge clk); #1;
    chk1("t6_sync_before", sync_err, 1'b0);
    rd_done = 1;
    @(posedge clk); #1 rd_done = 0; start = 0;
    chk1("t6_sync_set", sync_err, 1'b1);
    wait_fd("t6_frame_done", 400);
    repeat (5) @(negedge clk);
    chk1("t6_sync_sticky", sync_err, 1'b1);
    chk32("t6_issued", iss, FP);
    chk32("t6_pixels", npix, FP);
    chk32("t6_last_pixel", pd[FP-1], 32'(FP - 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog");
  end

endmodule
